// File: rtl/xip_pkg.sv
// Shared XIP definitions: AXI response codes and the fetch-master state encoding.
package xip_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrAddr,
      StWrResp
   } fm_state_e;

endpackage

// File: rtl/xip_fetch_master.sv
// AXI4-Lite master for the XIP slave: critical-word-first line fills and single-word writes,
// one transaction outstanding, results delivered through a one-entry response register.
module xip_fetch_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WORDS = 8,
   parameter bit          WRAP_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   input  logic [3:0]            req_wstrb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_data_o,
   output logic                  rsp_last_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] m_awaddr_o,
   output logic                  m_awvalid_o,
   input  logic                  m_awready_i,
   output logic [31:0]           m_wdata_o,
   output logic [3:0]            m_wstrb_o,
   output logic                  m_wvalid_o,
   input  logic                  m_wready_i,
   input  logic [1:0]            m_bresp_i,
   input  logic                  m_bvalid_i,
   output logic                  m_bready_o,
   output logic [ADDR_WIDTH-1:0] m_araddr_o,
   output logic                  m_arvalid_o,
   input  logic                  m_arready_i,
   input  logic [31:0]           m_rdata_i,
   input  logic [1:0]            m_rresp_i,
   input  logic                  m_rvalid_i,
   output logic                  m_rready_o,
   output logic                  busy_o
);
   import xip_pkg::*;

   localparam int unsigned IW = $clog2(LINE_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

   fm_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [IW-1:0]         idx0_q, idx0_d;
   logic [IW-1:0]         cnt_q, cnt_d;
   logic                  arvalid_q, arvalid_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic                  rsp_last_q, rsp_last_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [ADDR_WIDTH-1:0] req_addr_w;
   logic [IW-1:0]         req_idx;
   logic                  rsp_room;
   logic                  r_take;
   logic                  b_take;
   logic                  beat_last;

   // The index is IW bits wide, so the wrap inside the line is the natural overflow.
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [IW-1:0]         idx);
      return base | (ADDR_WIDTH'(idx) << 2);
   endfunction

   assign req_addr_w = req_addr_i & ~ADDR_WIDTH'(3);
   assign req_idx    = WRAP_EN ? req_addr_w[2 +: IW] : '0;
   assign rsp_room   = !rsp_valid_q || rsp_ready_i;
   assign beat_last  = (cnt_q == IW'(LINE_WORDS - 1));

   assign req_ready_o = resetn && (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign m_rready_o  = (state_q == StRdData) && rsp_room;
   assign m_bready_o  = (state_q == StWrResp) && rsp_room;
   assign r_take      = m_rvalid_i && m_rready_o;
   assign b_take      = m_bvalid_i && m_bready_o;

   assign m_araddr_o  = araddr_q;
   assign m_arvalid_o = arvalid_q;
   assign m_awaddr_o  = awaddr_q;
   assign m_awvalid_o = awvalid_q;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = wstrb_q;
   assign m_wvalid_o  = wvalid_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_last_o  = rsp_last_q;
   assign rsp_err_o   = rsp_err_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      araddr_d    = araddr_q;
      awaddr_d    = awaddr_q;
      idx0_d      = idx0_q;
      cnt_d       = cnt_q;
      arvalid_d   = arvalid_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q && !rsp_ready_i;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = rsp_last_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               if (req_write_i) begin
                  awaddr_d  = req_addr_w;
                  wdata_d   = req_wdata_i;
                  wstrb_d   = req_wstrb_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrAddr;
               end else begin
                  base_d    = req_addr_w & ~LINE_MASK;
                  idx0_d    = req_idx;
                  cnt_d     = '0;
                  araddr_d  = beat_addr(req_addr_w & ~LINE_MASK, req_idx);
                  arvalid_d = 1'b1;
                  state_d   = StRdAddr;
               end
            end
         end
         StRdAddr: begin
            if (m_arready_i) begin
               arvalid_d = 1'b0;
               state_d   = StRdData;
            end
         end
         StRdData: begin
            if (r_take) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = m_rdata_i;
               rsp_last_d  = beat_last;
               rsp_err_d   = (m_rresp_i != AXI_RESP_OKAY);
               if (beat_last) begin
                  state_d = StIdle;
               end else begin
                  cnt_d     = cnt_q + IW'(1);
                  araddr_d  = beat_addr(base_q, idx0_q + cnt_q + IW'(1));
                  arvalid_d = 1'b1;
                  state_d   = StRdAddr;
               end
            end
         end
         StWrAddr: begin
            if (m_awready_i) awvalid_d = 1'b0;
            if (m_wready_i)  wvalid_d  = 1'b0;
            if ((!awvalid_q || m_awready_i) && (!wvalid_q || m_wready_i)) state_d = StWrResp;
         end
         StWrResp: begin
            if (b_take) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_last_d  = 1'b1;
               rsp_err_d   = (m_bresp_i != AXI_RESP_OKAY);
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= StIdle;
         base_q      <= '0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
         idx0_q      <= '0;
         cnt_q       <= '0;
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         araddr_q    <= araddr_d;
         awaddr_q    <= awaddr_d;
         idx0_q      <= idx0_d;
         cnt_q       <= cnt_d;
         arvalid_q   <= arvalid_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_xip_fetch_master.sv
// Bench for xip_fetch_master: a WRAP_EN=1 and a WRAP_EN=0 instance share one randomized AXI
// slave model; observed beats are compared with a line-arithmetic reference.
module tb_xip_fetch_master;
   import xip_pkg::*;

   localparam int LW = 8;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        err;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        sel_nw;
   int          vectors = 0;
   int          miscompares = 0;

   logic        req_valid, req_write, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata;

   logic        req_ready, rsp_valid, rsp_last, rsp_err, m_awvalid, m_wvalid, m_bready;
   logic        m_arvalid, m_rready, busy;
   logic [31:0] rsp_data, m_awaddr, m_wdata, m_araddr;
   logic [3:0]  m_wstrb;

   logic        a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err, a_awvalid, a_wvalid, a_bready;
   logic        a_arvalid, a_rready, a_busy;
   logic [31:0] a_rsp_data, a_awaddr, a_wdata, a_araddr;
   logic [3:0]  a_wstrb;
   logic        b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err, b_awvalid, b_wvalid, b_bready;
   logic        b_arvalid, b_rready, b_busy;
   logic [31:0] b_rsp_data, b_awaddr, b_wdata, b_araddr;
   logic [3:0]  b_wstrb;

   xip_fetch_master #(.ADDR_WIDTH(32), .LINE_WORDS(LW), .WRAP_EN(1'b1)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid_i(req_valid && !sel_nw), .req_ready_o(a_req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready && !sel_nw), .rsp_data_o(a_rsp_data),
      .rsp_last_o(a_rsp_last), .rsp_err_o(a_rsp_err),
      .m_awaddr_o(a_awaddr), .m_awvalid_o(a_awvalid), .m_awready_i(m_awready && !sel_nw),
      .m_wdata_o(a_wdata), .m_wstrb_o(a_wstrb), .m_wvalid_o(a_wvalid),
      .m_wready_i(m_wready && !sel_nw), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid && !sel_nw),
      .m_bready_o(a_bready), .m_araddr_o(a_araddr), .m_arvalid_o(a_arvalid),
      .m_arready_i(m_arready && !sel_nw), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
      .m_rvalid_i(m_rvalid && !sel_nw), .m_rready_o(a_rready), .busy_o(a_busy)
   );

   xip_fetch_master #(.ADDR_WIDTH(32), .LINE_WORDS(LW), .WRAP_EN(1'b0)) dut_nw (
      .clk(clk), .resetn(resetn),
      .req_valid_i(req_valid && sel_nw), .req_ready_o(b_req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready && sel_nw), .rsp_data_o(b_rsp_data),
      .rsp_last_o(b_rsp_last), .rsp_err_o(b_rsp_err),
      .m_awaddr_o(b_awaddr), .m_awvalid_o(b_awvalid), .m_awready_i(m_awready && sel_nw),
      .m_wdata_o(b_wdata), .m_wstrb_o(b_wstrb), .m_wvalid_o(b_wvalid),
      .m_wready_i(m_wready && sel_nw), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid && sel_nw),
      .m_bready_o(b_bready), .m_araddr_o(b_araddr), .m_arvalid_o(b_arvalid),
      .m_arready_i(m_arready && sel_nw), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
      .m_rvalid_i(m_rvalid && sel_nw), .m_rready_o(b_rready), .busy_o(b_busy)
   );

   assign {req_ready, rsp_valid, rsp_last, rsp_err, m_awvalid, m_wvalid, m_bready, m_arvalid,
           m_rready, busy, rsp_data, m_awaddr, m_wdata, m_araddr, m_wstrb} = sel_nw ?
          {b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err, b_awvalid, b_wvalid, b_bready,
           b_arvalid, b_rready, b_busy, b_rsp_data, b_awaddr, b_wdata, b_araddr, b_wstrb} :
          {a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err, a_awvalid, a_wvalid, a_bready,
           a_arvalid, a_rready, a_busy, a_rsp_data, a_awaddr, a_wdata, a_araddr, a_wstrb};

   // Slave model state and observation logs
   logic [31:0] ar_log[$];
   logic [31:0] aw_log[$];
   logic [35:0] w_log[$];
   beat_t       rsp_log[$];
   logic [31:0] exp_ar[$];
   beat_t       exp_beats[$];
   logic [31:0] last_araddr = '0;
   bit          r_due = 0, b_due = 0, wr_aw_seen = 0, wr_w_seen = 0;
   bit          err_en = 0, aw_after_w = 0, holding = 0, hold_used = 0;
   logic [31:0] err_addr = '0;
   logic [1:0]  bresp_cfg = 2'b00;
   int          hold_at = -1;
   int          hold_left = 0;
   int          aw_wait = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] addr, input int i, input bit wrap);
      int unsigned line_bytes = LW * 4;
      int unsigned idx0 = wrap ? (addr % line_bytes) / 4 : 0;
      return (addr - (addr % line_bytes)) + ((idx0 + i) % LW) * 4;
   endfunction

   function automatic void add_line(input logic [31:0] addr, input bit wrap);
      for (int i = 0; i < LW; i++) begin
         logic [31:0] ea = exp_addr(addr, i, wrap);
         exp_ar.push_back(ea);
         exp_beats.push_back({mem_word(ea), (i == LW - 1), (err_en && ea == err_addr)});
      end
   endfunction

   // Handshake monitor: samples pre-edge values at the active edge
   always @(posedge clk) begin
      if (!resetn) begin
         r_due <= 0; b_due <= 0; wr_aw_seen <= 0; wr_w_seen <= 0;
      end else begin
         if (m_arvalid && m_arready) begin
            ar_log.push_back(m_araddr);
            last_araddr <= m_araddr;
            r_due <= 1;
         end
         if (m_rvalid && m_rready) r_due <= 0;
         if (m_awvalid && m_awready) aw_log.push_back(m_awaddr);
         if (m_wvalid && m_wready) w_log.push_back({m_wstrb, m_wdata});
         if ((wr_aw_seen || (m_awvalid && m_awready)) && (wr_w_seen || (m_wvalid && m_wready)))
         begin
            b_due <= 1; wr_aw_seen <= 0; wr_w_seen <= 0;
         end else begin
            if (m_awvalid && m_awready) wr_aw_seen <= 1;
            if (m_wvalid && m_wready) wr_w_seen <= 1;
         end
         if (m_bvalid && m_bready) b_due <= 0;
         if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_data, rsp_last, rsp_err});
      end
   end

   // Slave and response-consumer driver, updated on the falling edge
   initial begin
      {m_arready, m_rvalid, m_awready, m_wready, m_bvalid, rsp_ready} = '0;
      m_rdata = '0; m_rresp = '0; m_bresp = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
         end else begin
            m_arready = 1'($urandom_range(0, 1));
            m_rvalid  = r_due && (m_rvalid || ($urandom_range(0, 2) != 0));
            m_rdata   = mem_word(last_araddr);
            m_rresp   = (err_en && last_araddr == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (aw_after_w) begin
               m_wready  = 1'b1;
               aw_wait   = wr_w_seen ? aw_wait + 1 : 0;
               m_awready = (aw_wait >= 3);
            end else begin
               m_awready = 1'($urandom_range(0, 1));
               m_wready  = 1'($urandom_range(0, 1));
            end
            m_bvalid = b_due && (m_bvalid || ($urandom_range(0, 1) != 0));
            m_bresp  = bresp_cfg;
         end
         if (hold_at < 0) hold_used = 0;
         else if (!hold_used && rsp_log.size() == hold_at) begin
            hold_left = 10; hold_used = 1;
         end
         holding = (hold_left > 0);
         if (holding) hold_left--;
         rsp_ready = holding ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic clear_logs;
      ar_log.delete(); aw_log.delete(); w_log.delete(); rsp_log.delete();
      exp_ar.delete(); exp_beats.delete();
   endtask

   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output bit ok);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         if (req_ready) ok = 1;
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_beats(input int n, output bit ok);
      ok = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(posedge clk); #2;
         if (rsp_log.size() >= n && !busy && !rsp_valid) ok = 1;
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({req_ready, busy, rsp_valid, rsp_last, rsp_err, m_bready, m_rready} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {req_ready, busy, rsp_valid, rsp_last, rsp_err, m_bready, m_rready});
      end
      vectors++;
      if ({m_arvalid, m_awvalid, m_wvalid} !== 3'b0) begin
         miscompares++;
         $display("FAIL reset_valids: got %b want 000", {m_arvalid, m_awvalid, m_wvalid});
      end
      vectors++;
      if ({rsp_data, m_araddr, m_awaddr, m_wdata, m_wstrb} !== 132'b0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h %h want all 0",
                  rsp_data, m_araddr, m_awaddr, m_wdata, m_wstrb);
      end
      @(negedge clk); resetn = 1'b1; #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_wrap_read;
      logic [31:0] spec_seq[8];
      logic [31:0] addr, got_a;
      beat_t       got_b;
      bit          ok1, ok2;
      spec_seq = '{32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                   32'h1010};
      for (int t = 0; t < 4; t++) begin
         addr = (t == 0) ? 32'h1016 : ($urandom & 32'h000F_FFFF);
         clear_logs(); add_line(addr, 1'b1);
         issue(1'b0, addr, '0, '0, ok1); wait_beats(LW, ok2);
         vectors++;
         if (!(ok1 && ok2)) begin
            miscompares++;
            $display("FAIL wrap_done: got %0d beats busy=%b want %0d beats idle",
                     rsp_log.size(), busy, LW);
         end
         vectors++;
         if (rsp_log.size() != LW || ar_log.size() != LW) begin
            miscompares++;
            $display("FAIL wrap_count: got ar=%0d rsp=%0d want %0d", ar_log.size(),
                     rsp_log.size(), LW);
         end
         for (int i = 0; i < LW; i++) begin
            got_a = (i < ar_log.size()) ? ar_log[i] : 'x;
            got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
            vectors++;
            if (got_a !== exp_ar[i]) begin
               miscompares++; $display("FAIL wrap_araddr[%0d]: got %h want %h", i, got_a, exp_ar[i]);
            end
            if (t == 0) begin
               vectors++;
               if (got_a !== spec_seq[i]) begin
                  miscompares++;
                  $display("FAIL wrap_0x1016[%0d]: got %h want %h", i, got_a, spec_seq[i]);
               end
            end
            vectors++;
            if (got_b !== exp_beats[i]) begin
               miscompares++;
               $display("FAIL wrap_beat[%0d]: got %h want %h", i, got_b, exp_beats[i]);
            end
         end
      end
   endtask

   task automatic test_nowrap_read;
      logic [31:0] addr, got_a;
      beat_t       got_b;
      bit          ok1, ok2;
      sel_nw = 1'b1;
      for (int t = 0; t < 3; t++) begin
         addr = (t == 0) ? 32'h2024 : ($urandom & 32'h000F_FFFF);
         clear_logs(); add_line(addr, 1'b0);
         issue(1'b0, addr, '0, '0, ok1); wait_beats(LW, ok2);
         vectors++;
         if (!(ok1 && ok2) || ar_log.size() != LW || rsp_log.size() != LW) begin
            miscompares++;
            $display("FAIL nowrap_done: got ar=%0d rsp=%0d want %0d", ar_log.size(),
                     rsp_log.size(), LW);
         end
         for (int i = 0; i < LW; i++) begin
            got_a = (i < ar_log.size()) ? ar_log[i] : 'x;
            got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
            vectors++;
            if (got_a !== exp_ar[i] || got_b !== exp_beats[i]) begin
               miscompares++;
               $display("FAIL nowrap_beat[%0d]: got %h/%h want %h/%h", i, got_a, got_b,
                        exp_ar[i], exp_beats[i]);
            end
         end
      end
      sel_nw = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [31:0] addr;
      beat_t       got_b;
      bit          ok1, ok2;
      int          hold_seen = 0;
      addr = $urandom & 32'h000F_FFFF;
      clear_logs(); add_line(addr, 1'b1);
      hold_at = 2;
      issue(1'b0, addr, '0, '0, ok1);
      ok2 = 0;
      for (int c = 0; c < 3000 && !ok2; c++) begin
         @(posedge clk); #2;
         if (holding) begin
            hold_seen++;
            vectors++;
            if ((rsp_valid && m_rready) || rsp_log.size() != 2) begin
               miscompares++;
               $display("FAIL bp_hold: got rready=%b valid=%b beats=%0d want rready=0 beats=2",
                        m_rready, rsp_valid, rsp_log.size());
            end
         end
         if (rsp_log.size() >= LW && !busy && !rsp_valid) ok2 = 1;
      end
      hold_at = -1;
      vectors++;
      if (!(ok1 && ok2) || hold_seen != 10 || rsp_log.size() != LW) begin
         miscompares++;
         $display("FAIL bp_done: got hold=%0d beats=%0d want hold=10 beats=%0d", hold_seen,
                  rsp_log.size(), LW);
      end
      for (int i = 0; i < LW; i++) begin
         got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
         vectors++;
         if (got_b !== exp_beats[i]) begin
            miscompares++; $display("FAIL bp_beat[%0d]: got %h want %h", i, got_b, exp_beats[i]);
         end
      end
   endtask

   task automatic test_slverr;
      logic [31:0] addr;
      beat_t       got_b;
      bit          ok1, ok2;
      addr = $urandom & 32'h000F_FFFF;
      err_en = 1; err_addr = exp_addr(addr, 3, 1'b1);
      clear_logs(); add_line(addr, 1'b1);
      issue(1'b0, addr, '0, '0, ok1); wait_beats(LW, ok2);
      err_en = 0;
      vectors++;
      if (!(ok1 && ok2) || rsp_log.size() != LW) begin
         miscompares++; $display("FAIL err_done: got %0d beats want %0d", rsp_log.size(), LW);
      end
      for (int i = 0; i < LW; i++) begin
         got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
         vectors++;
         if (got_b !== exp_beats[i]) begin
            miscompares++; $display("FAIL err_beat[%0d]: got %h want %h", i, got_b, exp_beats[i]);
         end
      end
   endtask

   task automatic test_write;
      logic [31:0] addr, wd;
      logic [3:0]  ws;
      bit          ok1, ok2;
      for (int t = 0; t < 5; t++) begin
         addr = (t == 0) ? 32'h3000 : $urandom;
         wd   = (t == 0) ? 32'hDEAD_BEEF : $urandom;
         ws   = (t == 0) ? 4'hF : 4'($urandom);
         aw_after_w = (t == 0);
         bresp_cfg  = (t == 0) ? AXI_RESP_OKAY : 2'($urandom_range(0, 3));
         clear_logs();
         issue(1'b1, addr, wd, ws, ok1); wait_beats(1, ok2);
         vectors++;
         if (!(ok1 && ok2) || aw_log.size() != 1 || w_log.size() != 1 || rsp_log.size() != 1)
         begin
            miscompares++;
            $display("FAIL wr_count: got aw=%0d w=%0d rsp=%0d want 1 1 1", aw_log.size(),
                     w_log.size(), rsp_log.size());
         end else begin
            vectors++;
            if (aw_log[0] !== addr - (addr % 4) || w_log[0] !== {ws, wd}) begin
               miscompares++;
               $display("FAIL wr_aw_w: got %h %h want %h %h", aw_log[0], w_log[0],
                        addr - (addr % 4), {ws, wd});
            end
            vectors++;
            if (rsp_log[0] !== {32'h0, 1'b1, (bresp_cfg != 2'b00)}) begin
               miscompares++;
               $display("FAIL wr_rsp: got %h want %h", rsp_log[0],
                        {32'h0, 1'b1, (bresp_cfg != 2'b00)});
            end
         end
      end
      aw_after_w = 0; bresp_cfg = AXI_RESP_OKAY;
   endtask

   task automatic test_back_to_back;
      logic [31:0] a0, a1;
      beat_t       got_b;
      bit          ok1, ok2, ok3;
      a0 = $urandom & 32'h000F_FFFF; a1 = $urandom & 32'h000F_FFFF;
      clear_logs(); add_line(a0, 1'b1); add_line(a1, 1'b1);
      issue(1'b0, a0, '0, '0, ok1);
      ok3 = 0;
      for (int c = 0; c < 3000 && !ok3; c++) begin
         @(posedge clk); #2;
         if (!busy) ok3 = 1;
      end
      issue(1'b0, a1, '0, '0, ok2); ok1 = ok1 && ok2 && ok3;
      wait_beats(2 * LW, ok2);
      vectors++;
      if (!(ok1 && ok2) || rsp_log.size() != 2 * LW) begin
         miscompares++;
         $display("FAIL b2b_done: got %0d beats want %0d", rsp_log.size(), 2 * LW);
      end
      for (int i = 0; i < 2 * LW; i++) begin
         got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
         vectors++;
         if (got_b !== exp_beats[i]) begin
            miscompares++; $display("FAIL b2b_beat[%0d]: got %h want %h", i, got_b, exp_beats[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] addr;
      beat_t       got_b;
      bit          ok1, ok2;
      addr = $urandom & 32'h000F_FFFF;
      clear_logs();
      issue(1'b0, addr, '0, '0, ok1);
      ok2 = 0;
      for (int c = 0; c < 3000 && !ok2; c++) begin
         @(posedge clk); #2;
         if (ar_log.size() >= 5) ok2 = 1;
      end
      @(negedge clk); resetn = 1'b0;
      @(posedge clk); #2;
      vectors++;
      if (!(ok1 && ok2) || {m_arvalid, m_awvalid, m_wvalid, rsp_valid, busy, m_rready, m_bready}
          !== 7'b0) begin
         miscompares++;
         $display("FAIL rst_mid_state: got %b want 0000000",
                  {m_arvalid, m_awvalid, m_wvalid, rsp_valid, busy, m_rready, m_bready});
      end
      @(negedge clk); resetn = 1'b1; #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL rst_mid_ready: got %b want 1", req_ready);
      end
      addr = $urandom & 32'h000F_FFFF;
      clear_logs(); add_line(addr, 1'b1);
      issue(1'b0, addr, '0, '0, ok1); wait_beats(LW, ok2);
      vectors++;
      if (!(ok1 && ok2) || rsp_log.size() != LW) begin
         miscompares++; $display("FAIL rst_mid_refill: got %0d beats want %0d", rsp_log.size(), LW);
      end
      for (int i = 0; i < LW; i++) begin
         got_b = (i < rsp_log.size()) ? rsp_log[i] : 'x;
         vectors++;
         if (got_b !== exp_beats[i]) begin
            miscompares++;
            $display("FAIL rst_mid_beat[%0d]: got %h want %h", i, got_b, exp_beats[i]);
         end
      end
   endtask

   initial begin
      sel_nw = 1'b0; resetn = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      test_reset();
      test_wrap_read();
      test_nowrap_read();
      test_backpressure();
      test_slverr();
      test_write();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
